// File: rtl/uart_rx_buffered_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffered_if
// Description : Pop-side bus of the buffered UART receiver: FIFO head word
//               with its error flags, valid/ready pop handshake, sticky
//               overrun with clear, and FIFO occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_buffered_if #(
  parameter int WORD_LENGTH = 8,
  parameter int FIFO_DEPTH  = 16
);
  logic [WORD_LENGTH-1:0]        rx_data;
  logic                          rx_parity_err;
  logic                          rx_frame_err;
  logic                          rx_break;
  logic                          rx_data_valid;
  logic                          rx_data_ready;
  logic                          overrun;
  logic                          overrun_clear;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // Receiver side: produces words, consumes pop and clear requests
  modport master (
    output rx_data, rx_parity_err, rx_frame_err, rx_break,
    output rx_data_valid, overrun, fifo_count,
    input  rx_data_ready, overrun_clear
  );

  // Consumer side
  modport slave (
    input  rx_data, rx_parity_err, rx_frame_err, rx_break,
    input  rx_data_valid, overrun, fifo_count,
    output rx_data_ready, overrun_clear
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_buffered
// Description : UART receiver with 16x oversampling and 3-sample majority
//               vote, optional even/odd parity, 1 or 2 stop bits, break
//               detection and a first-word-fall-through receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buffered #(
  parameter int CLOCKRATE   = 100000000,
  parameter int BAUD        = 115200,
  parameter int WORD_LENGTH = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                UART_RX,
  output logic [2:0]          current_state_debug,
  uart_rx_buffered_if.master  bus
);

  localparam int c_OS_DIV = CLOCKRATE / (BAUD * 16);
  localparam int c_DIV_W  = (c_OS_DIV > 2) ? $clog2(c_OS_DIV) : 1;
  localparam int c_AW     = $clog2(FIFO_DEPTH);
  localparam int c_EW     = WORD_LENGTH + 3;

  localparam logic [c_DIV_W-1:0] c_DIV_MAX   = c_DIV_W'(c_OS_DIV - 1);
  localparam logic [3:0]         c_WORD_LAST = 4'(WORD_LENGTH - 1);
  localparam logic               c_STOP_LAST = 1'(STOP_BITS == 2);
  localparam logic [c_AW:0]      c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_START     = 3'd1;
  localparam logic [2:0] c_DATA      = 3'd2;
  localparam logic [2:0] c_PARITY    = 3'd3;
  localparam logic [2:0] c_STOP      = 3'd4;
  localparam logic [2:0] c_WAIT_HIGH = 3'd5;

  // Reject configurations the datapath cannot support
  generate
    if (c_OS_DIV < 2) begin : g_bad_os_div
      $error("uart_rx_buffered: CLOCKRATE/(BAUD*16) must be >= 2");
    end
    if (WORD_LENGTH < 5 || WORD_LENGTH > 9) begin : g_bad_word
      $error("uart_rx_buffered: WORD_LENGTH must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_rx_buffered: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_rx_buffered: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (1 << c_AW) != FIFO_DEPTH) begin : g_bad_depth
      $error("uart_rx_buffered: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic                   r_sync1;
  logic                   r_rx_s;
  logic [c_DIV_W-1:0]     r_div;
  logic [3:0]             r_idx;
  logic                   r_s7;
  logic                   r_s8;
  logic [2:0]             r_state;
  logic [WORD_LENGTH-1:0] r_shift;
  logic [3:0]             r_bit_cnt;
  logic                   r_stop_cnt;
  logic                   r_par_bit;
  logic                   r_par_err;

  logic                   w_tick;
  logic                   w_t9;
  logic                   w_t15;
  logic                   w_maj;
  logic                   w_enter_start;
  logic                   w_push;
  logic                   w_frame;
  logic                   w_brk;

  // Two-flop synchroniser for the asynchronous line, idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_enter_start = (r_state == c_IDLE) && !r_rx_s;
  assign w_tick        = (r_div == c_DIV_MAX);
  assign w_t9          = w_tick && (r_idx == 4'd9);
  assign w_t15         = w_tick && (r_idx == 4'd15);
  assign w_maj         = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);

  // Oversampling tick divider and 0..15 sample index, phase-locked to the start edge
  always_ff @(posedge clk) begin
    if (reset || w_enter_start) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Capture the first two of the three vote samples; the third is live at index 9
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s7 <= 1'b1;
      r_s8 <= 1'b1;
    end else begin
      if (w_tick && r_idx == 4'd7) r_s7 <= r_rx_s;
      if (w_tick && r_idx == 4'd8) r_s8 <= r_rx_s;
    end
  end

  // Push decision: first zero stop bit ends the frame early, else the last stop bit
  always_comb begin
    w_push  = 1'b0;
    w_frame = 1'b0;
    w_brk   = 1'b0;
    if (r_state == c_STOP && w_t9) begin
      if (!w_maj) begin
        w_push  = 1'b1;
        w_frame = 1'b1;
        w_brk   = !r_stop_cnt && (r_shift == '0) && !r_par_bit;
      end else if (r_stop_cnt == c_STOP_LAST) begin
        w_push  = 1'b1;
      end
    end
  end

  // Frame state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_par_bit  <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (!r_rx_s) begin
            r_state    <= c_START;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_bit  <= 1'b0;
            r_par_err  <= 1'b0;
          end
        end
        c_START: begin
          if (w_t9 && w_maj) begin
            r_state <= c_IDLE;
          end else if (w_t15) begin
            r_state <= c_DATA;
          end
        end
        c_DATA: begin
          if (w_t9) begin
            r_shift <= {w_maj, r_shift[WORD_LENGTH-1:1]};
          end
          if (w_t15) begin
            if (r_bit_cnt == c_WORD_LAST) begin
              r_state <= (PARITY_MODE != 0) ? c_PARITY : c_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        c_PARITY: begin
          if (w_t9) begin
            r_par_bit <= w_maj;
            r_par_err <= ((^r_shift) ^ w_maj) != (PARITY_MODE == 2);
          end
          if (w_t15) begin
            r_state <= c_STOP;
          end
        end
        c_STOP: begin
          if (w_t9 && !w_maj) begin
            r_state <= c_WAIT_HIGH;
          end else if (w_t9 && r_stop_cnt == c_STOP_LAST) begin
            r_state <= c_IDLE;
          end else if (w_t15) begin
            r_stop_cnt <= 1'b1;
          end
        end
        c_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign current_state_debug = r_state;

  // ---------------------------------------------------------------- FIFO --
  logic [c_EW-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic            r_overrun;

  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_wr;
  logic [c_EW-1:0] w_entry;
  logic [c_EW-1:0] w_head;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = w_valid && bus.rx_data_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_entry = {w_brk, w_frame, r_par_err, r_shift};
  assign w_head  = r_mem[r_rptr];

  // Storage array; written only when there is room (or a same-cycle pop)
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (bus.overrun_clear) begin
      r_overrun <= 1'b0;
    end
  end

  // Head outputs forced to zero when empty so stale storage never leaks out
  assign bus.rx_data       = w_valid ? w_head[WORD_LENGTH-1:0] : '0;
  assign bus.rx_parity_err = w_valid & w_head[WORD_LENGTH];
  assign bus.rx_frame_err  = w_valid & w_head[WORD_LENGTH+1];
  assign bus.rx_break      = w_valid & w_head[WORD_LENGTH+2];
  assign bus.rx_data_valid = w_valid;
  assign bus.overrun       = r_overrun;
  assign bus.fifo_count    = r_count;

endmodule
`default_nettype wire

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Parametrised UART receiver, successor to the single-word receiver. Adds 16x oversampling with 3-sample majority vote, selectable parity (none/even/odd), 1 or 2 stop bits, and break detection. Received words, with per-word error flags, go into an internal first-word-fall-through FIFO with a valid/ready pop interface and a sticky overrun flag. Sits between the board UART_RX pin and the consumer logic (command decoder / DMA).

## Interface
- CLOCKRATE, 100000000, clk frequency in Hz
- BAUD, 115200, line rate; OS_DIV = CLOCKRATE/(BAUD*16) must be >= 2 (elaboration error otherwise)
- WORD_LENGTH, 8, data bits per frame, legal 5..9
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, entries, power of two >= 2
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- UART_RX  in  1  asynchronous serial line, idle high
- rx_data  out  WORD_LENGTH  FIFO head data, LSB received first
- rx_parity_err  out  1  head entry parity mismatch (always 0 when PARITY_MODE = 0)
- rx_frame_err  out  1  head entry had a stop bit sampled 0
- rx_break  out  1  head entry was a break (all data, parity and first stop bit 0)
- rx_data_valid  out  1  FIFO not empty
- rx_data_ready  in  1  consumer pop request
- overrun  out  1  sticky: a word was dropped because the FIFO was full
- overrun_clear  in  1  clears overrun
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- current_state_debug  out  3  FSM state encoding

## Operation
- UART_RX passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised line rx_s.
- Tick generator: counter 0..OS_DIV-1; a tick pulse is produced on wrap. Counter and sample index (0..15) are cleared on entry to START.
- Per bit, samples at ticks with index 7, 8, 9; bit value = majority of the three, decided at index 9; the state advances at index 15.
- FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_HIGH=5.
- IDLE: rx_s == 0 -> START.
- START: majority 1 at index 9 -> IDLE (glitch rejected, no push); otherwise -> DATA at index 15.
- DATA: shift majority bits in LSB first; after WORD_LENGTH bits -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: capture the bit. Error if (^data ^ bit) != 0 for even, or != 1 for odd.
- STOP: STOP_BITS bits. Any stop bit 0 sets frame_err.
- Push at index 9 of the last stop bit, or at index 9 of the first stop bit if that bit is 0 (remaining stop bits are skipped).
- Break: data == 0, parity bit (if any) == 0 and first stop bit 0 -> entry pushed with rx_break = 1 and rx_frame_err = 1.
- After push: stop bit 1 -> IDLE; frame error -> WAIT_HIGH, which returns to IDLE once rx_s == 1. This prevents a held-low line from retriggering.
- FIFO: entry is {break, frame_err, parity_err, data}. Pop when rx_data_valid && rx_data_ready.
- Push when full without a same-cycle pop: word dropped, overrun set, FIFO contents unchanged.
- Push when full with a same-cycle pop: both happen, count unchanged, no overrun.
- Pop when empty: ignored.
- overrun_clear and an overrun event in the same cycle: overrun stays set.

## Timing
- Reset values: rx_data 0, all flags 0, rx_data_valid 0, overrun 0, fifo_count 0, state IDLE. Reset mid-frame abandons the frame, flushes the FIFO and leaves nothing pushed.
- Synchroniser latency is 2 cycles. A start edge is seen in IDLE 2–3 cycles after the UART_RX fall.
- Push is registered: rx_data_valid rises 1 cycle after the push tick. rx_data and the flags are valid in the same cycle (first-word fall-through).
- After a pop, the next entry appears on the following cycle. fifo_count updates the cycle after push/pop.
- Back-to-back frames with no idle gap after the stop bit are received without loss.
- Baud tolerance: frames with up to ±3% rate error must decode correctly.

## Test plan
- CLOCKRATE=32_000_000, BAUD=1_000_000, 8N1: send 0xA5 then 0x3C back-to-back -> two entries in order, all flags 0, fifo_count reaches 2.
- PARITY_MODE=1: send 0x07 with parity bit 0 -> parity_err=1, data 0x07; resend with parity 1 -> parity_err=0.
- STOP_BITS=2: second stop bit 0 -> frame_err=1, FSM goes to WAIT_HIGH, then IDLE after the line rises; hold the line low for 3 frame times -> exactly one entry with rx_break=1.
- FIFO_DEPTH=4, rx_data_ready=0: send 5 frames -> fifo_count=4, overrun=1, entries are the first 4 words. Pulse overrun_clear -> overrun=0. Repeat with a pop on the 5th push cycle -> no overrun.
- 8-cycle low glitch on an idle line -> no push, FSM returns to IDLE. Frame sent at BAUD+3% -> correct data.
- Assert reset midway through DATA, then send 0x5A -> only 0x5A received, no stale entry.
